// File: rtl/instr_encoder.sv
// Streaming RISC-V instruction assembler: scatters an immediate into the format's
// bit positions, range-checks it and emits words with a sequential word address.
package types_pkg;
  typedef enum logic [2:0] {
    FMT_I  = 3'd0,
    FMT_S  = 3'd1,
    FMT_UI = 3'd2,
    FMT_B  = 3'd3,
    FMT_J  = 3'd4
  } instr_format;
endpackage

module instr_encoder
  import types_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  instr_format           fmt,
  input  logic [31:0]           base,
  input  logic [31:0]           imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_err,
  output logic [15:0]           err_count
);

  localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);

  logic                  outValid;
  logic [31:0]           outInstrReg;
  logic                  outErrReg;
  logic [ADDR_WIDTH-1:0] outAddrReg;
  logic                  skidFull;
  logic [31:0]           skidInstr;
  logic                  skidErr;
  logic [ADDR_WIDTH-1:0] addrCnt;
  logic [ADDR_WIDTH-1:0] nextAddr;
  logic [15:0]           errCnt;
  logic [31:0]           encInstr;
  logic                  encErr;
  logic signed [31:0]    immS;
  logic                  inFire;
  logic                  outFire;

  assign immS     = imm;
  assign in_ready = !skidFull && !flush;
  assign inFire   = in_valid && in_ready;
  assign outFire  = outValid && out_ready;

  // A word loaded while the current one leaves takes the address after it.
  assign nextAddr = outFire ? addrCnt + 1'b1 : addrCnt;

  always_comb begin
    encInstr = {imm[11:0], base[19:0]};
    encErr   = (immS < -32'sd2048) || (immS > 32'sd2047);
    case (fmt)
      FMT_S: begin
        encInstr = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        encErr   = (immS < -32'sd2048) || (immS > 32'sd2047);
      end
      FMT_UI: begin
        encInstr = {imm[31:12], base[11:0]};
        encErr   = (imm[11:0] != 12'd0);
      end
      FMT_B: begin
        encInstr = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        encErr   = (immS < -32'sd4096) || (immS > 32'sd4094) || imm[0];
      end
      FMT_J: begin
        encInstr = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        encErr   = (immS < -32'sd1048576) || (immS > 32'sd1048574) || imm[0];
      end
      default: begin
        encInstr = {imm[11:0], base[19:0]};
        encErr   = (immS < -32'sd2048) || (immS > 32'sd2047);
      end
    endcase
  end

  // Output register refills from the skid entry first, then from the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid    <= 1'b0;
      outInstrReg <= 32'd0;
      outErrReg   <= 1'b0;
      outAddrReg  <= BaseAddr;
      skidFull    <= 1'b0;
      skidInstr   <= 32'd0;
      skidErr     <= 1'b0;
      addrCnt     <= BaseAddr;
      errCnt      <= 16'd0;
    end else if (flush) begin
      outValid   <= 1'b0;
      skidFull   <= 1'b0;
      addrCnt    <= BaseAddr;
      outAddrReg <= BaseAddr;
    end else begin
      if (outFire) addrCnt <= addrCnt + 1'b1;
      if (!outValid || outFire) begin
        if (skidFull) begin
          outValid    <= 1'b1;
          outInstrReg <= skidInstr;
          outErrReg   <= skidErr;
          outAddrReg  <= nextAddr;
          skidFull    <= 1'b0;
        end else if (inFire) begin
          outValid    <= 1'b1;
          outInstrReg <= encInstr;
          outErrReg   <= encErr;
          outAddrReg  <= nextAddr;
        end else begin
          outValid <= 1'b0;
        end
      end else if (inFire) begin
        skidFull  <= 1'b1;
        skidInstr <= encInstr;
        skidErr   <= encErr;
      end
      if (inFire && encErr && (errCnt != 16'hFFFF)) errCnt <= errCnt + 16'd1;
    end
  end

  assign out_valid = outValid;
  assign out_instr = outInstrReg;
  assign out_err   = outErrReg;
  assign out_addr  = outAddrReg;
  assign err_count = errCnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words are queued on input
// acceptance and compared against every cycle the DUT presents an output.
module tb_instr_encoder;
  import types_pkg::*;

  localparam int AW   = 2;
  localparam int BASE = 0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  instr_format   fmt = FMT_I;
  logic [31:0]   base = 32'd0;
  logic [31:0]   imm = 32'd0;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          out_err;
  logic [15:0]   err_count;

  typedef struct {
    logic [31:0]   instr;
    logic [AW-1:0] addr;
    logic          err;
  } expT;

  expT           sbQ[$];
  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] expAddr = AW'(BASE);
  int            expErrCount = 0;
  int            readyMode = 0;
  logic          randBit = 1'b0;

  instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .base(base), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  assign out_ready = (readyMode == 1) || ((readyMode == 2) && randBit);

  always @(posedge clk) begin
    #2;
    randBit = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference encoder built from masks and shifts, with range limits as integers.
  function automatic logic [32:0] modelEncode(input instr_format f, input logic [31:0] b, input logic [31:0] im);
    int          v;
    logic [31:0] w;
    logic        e;
    v = im;
    case (f)
      FMT_S: begin
        w = (b & 32'h01FFF07F) | ((im & 32'hFE0) << 20) | ((im & 32'h1F) << 7);
        e = (v < -2048) || (v > 2047);
      end
      FMT_UI: begin
        w = (b & 32'h00000FFF) | (im & 32'hFFFFF000);
        e = (im & 32'hFFF) != 0;
      end
      FMT_B: begin
        w = (b & 32'h01FFF07F) | ((im & 32'h1000) << 19) | ((im & 32'h7E0) << 20)
          | ((im & 32'h1E) << 7) | ((im & 32'h800) >> 4);
        e = (v < -4096) || (v > 4094) || ((im & 1) != 0);
      end
      FMT_J: begin
        w = (b & 32'h00000FFF) | ((im & 32'h100000) << 11) | ((im & 32'h7FE) << 20)
          | ((im & 32'h800) << 9) | (im & 32'hFF000);
        e = (v < -1048576) || (v > 1048574) || ((im & 1) != 0);
      end
      default: begin
        w = (b & 32'h000FFFFF) | (im << 20);
        e = (v < -2048) || (v > 2047);
      end
    endcase
    return {e, w};
  endfunction

  task automatic applyStimulus(input instr_format f, input logic [31:0] b, input logic [31:0] im,
                               input logic [31:0] expInstr, input logic expErr);
    int   waitCnt = 0;
    logic accepted = 1'b0;
    in_valid = 1'b1;
    fmt = f;
    base = b;
    imm = im;
    while (!accepted && waitCnt < 50) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        sbQ.push_back('{expInstr, expAddr, expErr});
        expAddr = expAddr + 1'b1;
        if (expErr && expErrCount < 65535) expErrCount++;
      end
      @(posedge clk);
      #1;
      waitCnt++;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("accept timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic applyModelled(input instr_format f, input logic [31:0] b, input logic [31:0] im);
    logic [32:0] r;
    r = modelEncode(f, b, im);
    applyStimulus(f, b, im, r[31:0], r[32]);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sbQ.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", 32'(sbQ.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush && out_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("out_valid unexpected", 32'(out_valid), 32'd0);
      end else begin
        checkOutput("out_instr", out_instr, sbQ[0].instr);
        checkOutput("out_addr", 32'(out_addr), 32'(sbQ[0].addr));
        checkOutput("out_err", 32'(out_err), 32'(sbQ[0].err));
        if (out_ready) void'(sbQ.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] im;
    #3;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_instr", out_instr, 32'd0);
    checkOutput("reset out_err", 32'(out_err), 32'd0);
    checkOutput("reset out_addr", 32'(out_addr), 32'(BASE));
    checkOutput("reset err_count", 32'(err_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("in_ready after reset", 32'(in_ready), 32'd1);

    readyMode = 1;
    applyStimulus(FMT_I, 32'h00000093, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    checkOutput("latency out_valid", 32'(out_valid), 32'd1);
    applyStimulus(FMT_S, 32'h0020A023, 32'd8, 32'h0020A423, 1'b0);
    applyStimulus(FMT_B, 32'h00000063, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
    applyStimulus(FMT_I, 32'h00000093, 32'h00000800, 32'h80000093, 1'b1);
    applyStimulus(FMT_J, 32'h0000006F, 32'd3, 32'h0020006F, 1'b1);
    applyStimulus(FMT_UI, 32'h000002B7, 32'h12345001, 32'h123452B7, 1'b1);
    waitDrain();
    checkOutput("err_count three", 32'(err_count), 32'd3);

    // Backpressure: two words fill output and skid, then the stream stalls.
    readyMode = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) applyModelled(FMT_I, 32'h00000013 | (i << 7), 32'(i * 37 - 100));
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("in_ready backpressure", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        readyMode = 1;
      end
    join
    waitDrain();

    for (int i = 0; i < 5; i++) applyModelled(FMT_S, 32'h00002023, 32'(i * 4));
    waitDrain();

    // Flush with a stalled word in flight and an erroneous input presented.
    readyMode = 0;
    applyModelled(FMT_B, 32'h00000063, 32'd16);
    in_valid = 1'b1;
    fmt = FMT_I;
    base = 32'h00000093;
    imm = 32'h00000800;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("in_ready during flush", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sbQ.delete();
    expAddr = AW'(BASE);
    checkOutput("flush out_valid", 32'(out_valid), 32'd0);
    checkOutput("flush err_count", 32'(err_count), 32'(expErrCount));
    readyMode = 1;
    applyModelled(FMT_I, 32'h00000013, 32'd5);
    waitDrain();

    // Asynchronous reset between edges while words are held.
    readyMode = 0;
    applyModelled(FMT_I, 32'h00000013, 32'h00001000);
    applyModelled(FMT_J, 32'h0000006F, 32'd2048);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset out_instr", out_instr, 32'd0);
    checkOutput("midreset out_err", 32'(out_err), 32'd0);
    checkOutput("midreset out_addr", 32'(out_addr), 32'(BASE));
    checkOutput("midreset err_count", 32'(err_count), 32'd0);
    sbQ.delete();
    expAddr = AW'(BASE);
    expErrCount = 0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    readyMode = 1;
    @(posedge clk);
    #1;
    checkOutput("in_ready after midreset", 32'(in_ready), 32'd1);

    readyMode = 2;
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) im = $urandom;
      else if (i % 3 == 1) im = ($urandom & 32'h00001FFE) - 32'h00001000;
      else im = ($urandom & 32'h00000FFF) - 32'h00000800;
      applyModelled(instr_format'($urandom_range(0, 7)), $urandom, im);
    end
    readyMode = 1;
    waitDrain();
    checkOutput("final err_count", 32'(err_count), 32'(expErrCount));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
